// File: rtl/slave_fabric.sv
// Single-master to N_CH-slave fabric: registered decode, one-hot chip select,
// wait-state tolerant ready handshake, timeout and error response.
module slave_fabric #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 16,
    parameter int unsigned MAW      = 8,
    parameter int unsigned SELW     = 2,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    input  logic               m_rw_,
    input  logic               m_req_,
    output logic [DW-1:0]      m_rdata,
    output logic               m_rdy_,
    output logic               m_err,
    output logic               busy,
    output logic [N_CH-1:0]    s_cs_,
    output logic [MAW-1:0]     s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic               s_rw_,
    input  logic [N_CH*DW-1:0] s_rdata,
    input  logic [N_CH-1:0]    s_rdy_,
    output logic [7:0]         err_cnt
);

    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    state_t            r_state,   w_state_nxt;
    logic [SELW-1:0]   r_sel,     w_sel_nxt;
    logic [CNTW-1:0]   r_cnt,     w_cnt_nxt;
    logic [N_CH-1:0]   r_cs_,     w_cs_nxt;
    logic [MAW-1:0]    r_addr,    w_addr_nxt;
    logic [DW-1:0]     r_wdata,   w_wdata_nxt;
    logic              r_rw_,     w_rw_nxt;
    logic              r_rdy_,    w_rdy_nxt;
    logic              r_err,     w_err_nxt;
    logic              r_busy,    w_busy_nxt;
    logic [DW-1:0]     r_rdata,   w_rdata_nxt;
    logic [7:0]        r_err_cnt, w_err_cnt_nxt;

    logic [SELW-1:0]   w_req_sel;
    logic              w_sel_rdy_;
    logic [DW-1:0]     w_sel_rdata;
    logic              w_fail;
    logic              w_unused;

    // Only the select field and the slave-local low bits of m_addr are decoded.
    assign w_unused  = ^m_addr;
    assign w_req_sel = m_addr[AW-1 -: SELW];

    // Ready/data of the channel owning the current transaction.
    always_comb begin
        w_sel_rdy_  = 1'b1;
        w_sel_rdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (r_sel == SELW'(i)) begin
                w_sel_rdy_  = s_rdy_[i];
                w_sel_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_cs_     <= '1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw_     <= 1'b1;
            r_rdy_    <= 1'b1;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata   <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cs_     <= w_cs_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rw_     <= w_rw_nxt;
            r_rdy_    <= w_rdy_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_cs_nxt      = r_cs_;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_rw_nxt      = r_rw_;
        w_rdy_nxt     = 1'b1;
        w_err_nxt     = r_err;
        w_rdata_nxt   = r_rdata;
        w_err_cnt_nxt = r_err_cnt;
        w_fail        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!m_req_) begin
                    w_addr_nxt  = m_addr[MAW-1:0];
                    w_wdata_nxt = m_wdata;
                    w_rw_nxt    = m_rw_;
                    w_sel_nxt   = w_req_sel;
                    w_cnt_nxt   = '0;
                    if (32'(w_req_sel) < N_CH) begin
                        w_state_nxt = ST_ACCESS;
                        for (int unsigned i = 0; i < N_CH; i++) begin
                            if (w_req_sel == SELW'(i)) w_cs_nxt[i] = 1'b0;
                        end
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready on the last allowed cycle takes priority over timeout.
                if (!w_sel_rdy_) begin
                    w_cs_nxt    = '1;
                    w_state_nxt = ST_DONE;
                    w_rdy_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = r_rw_ ? w_sel_rdata : '0;
                end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                    w_cs_nxt = '1;
                    w_fail   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_fail) begin
            w_state_nxt = ST_DONE;
            w_rdy_nxt   = 1'b0;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = DW'(ERR_DATA);
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign m_rdata = r_rdata;
    assign m_rdy_  = r_rdy_;
    assign m_err   = r_err;
    assign busy    = r_busy;
    assign s_cs_   = r_cs_;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign s_rw_   = r_rw_;
    assign err_cnt = r_err_cnt;

endmodule

// File: doc/slave_fabric.md
Name: slave_fabric

Overview:
- Parametrised successor to the fixed four-slave decoder/mux: one bus-master port fans out to N_CH slave channels.
- Registered address decode, per-transaction chip-select, slave ready handshake, wait-state support, timeout and error response for unmapped or unresponsive slaves.
- Sits between the bus master and the memory-mapped slaves (SRAMs, timer, DMAC).

Parameters:
N_CH, 4, number of slave channels (1..2**SELW)
DW, 32, data width
AW, 16, master bus address width
MAW, 8, slave-local address width (low bits of master address)
SELW, 2, channel-select field width, taken from m_addr[AW-1 -: SELW]
TIMEOUT, 16, max ACCESS cycles before error (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on error (truncated to DW)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
m_addr  in  AW  master address
m_wdata  in  DW  master write data
m_rw_  in  1  1=read, 0=write
m_req_  in  1  active-low single-cycle request pulse
m_rdata  out  DW  read data, valid while m_rdy_ low
m_rdy_  out  1  active-low, one-cycle completion strobe
m_err  out  1  high with m_rdy_ when transaction failed
busy  out  1  high while a transaction is in flight (state != IDLE)
s_cs_  out  N_CH  active-low one-hot chip selects
s_addr  out  MAW  latched m_addr[MAW-1:0]
s_wdata  out  DW  latched write data
s_rw_  out  1  latched direction
s_rdata  in  N_CH*DW  slave read data, channel i at [i*DW +: DW]
s_rdy_  in  N_CH  active-low slave ready per channel
err_cnt  out  8  saturating count of errored transactions

Behaviour:
- All outputs registered. On reset: state IDLE, s_cs_ all 1, m_rdy_=1, m_err=0, busy=0, m_rdata=0, s_addr/s_wdata=0, s_rw_=1, err_cnt=0, wait counter=0.
- Reset mid-transaction aborts it: no m_rdy_ strobe; s_cs_ deasserted at the reset edge.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - m_req_ low at edge: latch addr/wdata/rw_ and decode sel = m_addr[AW-1 -: SELW].
  - sel < N_CH: go to ACCESS, drive s_cs_[sel]=0 from the next cycle, wait counter cleared.
  - sel >= N_CH: go directly to DONE with error; no s_cs_ asserted.
- ACCESS:
  - Only s_rdy_[sel] is sampled; other channels' ready is ignored.
  - s_rdy_[sel]==0: capture s_rdata[sel] into m_rdata (reads only; writes leave m_rdata=0), deassert s_cs_, go to DONE, no error.
  - Otherwise increment wait counter.
  - If counter == TIMEOUT-1 and still not ready: deassert s_cs_, go to DONE with error.
  - Ready on the final cycle wins over timeout.
  - s_cs_ stays low for at most TIMEOUT cycles.
- DONE (one cycle): m_rdy_=0, m_err per outcome.
  - Error: m_rdata=ERR_DATA for reads and writes.
  - Error: err_cnt increments, saturating at 255.
  - Next state is always IDLE.
- Latency:
  - Zero-wait slave: req at edge T → cs_ low in cycle T+1 → m_rdy_ low in cycle T+2.
  - Each slave wait cycle adds one.
  - Unmapped access: m_rdy_ low in cycle T+1.
- m_req_ while busy is ignored (not queued). Back-to-back: a request in the first IDLE cycle after DONE is accepted.
- m_rdata and m_err are held outside DONE; m_rdata updates only on a DONE entry.
- At most one s_cs_ bit is low in any cycle.
- s_addr/s_wdata/s_rw_ are stable from the cs_ assertion until DONE.

Test Plan:
- Reset, then zero-wait read: m_addr=16'h4010, ch1 s_rdy_ tied low, s_rdata ch1=32'h1234_5678 → s_cs_=4'b1101 one cycle, s_addr=8'h10, m_rdy_ low 2 cycles after req, m_rdata=32'h1234_5678, m_err=0.
- Write with 3 wait states to ch0: m_addr=16'h0004, m_wdata=32'hCAFE_0001, s_rdy_[0] low on the 4th ACCESS cycle → s_cs_[0] low exactly 4 cycles, s_wdata/s_rw_=0 stable throughout, m_rdy_ at req+5, m_err=0.
- Timeout: ch2 never ready, TIMEOUT=16 → s_cs_[2] low exactly 16 cycles, then m_rdy_ low with m_err=1, m_rdata=32'hDEAD_BEEF, err_cnt=1. Same with ready on the 16th cycle → success, no error.
- Unmapped: N_CH=3, m_addr=16'hC000 → no s_cs_ asserted, m_rdy_ low one cycle after req, m_err=1, err_cnt increments. Repeat 300 times → err_cnt saturates at 255.
- Ignore-while-busy and back-to-back: a second req_ pulse during ACCESS → ignored, only one DONE. A req_ in the cycle after DONE → accepted.
- Reset mid-ACCESS: assert reset while s_cs_[1] is low → all s_cs_ high, m_rdy_ never strobes, busy=0, err_cnt=0 after the reset edge.
